// File: rtl/load_store_unit.sv
// load_store_unit
// Byte/halfword/word load-store sequencer sitting between the pipeline
// control and a simple request/acknowledge memory port.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   start, is_store,      : operation request (sampled in IDLE only),
//   funct3, addr, wdata     RV32I width/sign code, effective address, store data
//   busy, done, err       : status; err is meaningful only while done=1
//   rdata                 : extended load result, held until the next good load
//   mem_req, mem_we,      : memory request port, all held stable in REQ
//   mem_addr, mem_be,
//   mem_wdata
//   mem_ack, mem_rdata    : memory accept / read return
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_MISALGN = 2'b01;
    localparam logic [1:0]  ERR_FUNCT3  = 2'b10;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b11;
    // Last counter value before abort: counter runs 0..TIMEOUT-1, giving
    // exactly TIMEOUT cycles of mem_req.
    localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        op_store;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [15:0] wait_cnt;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;

    logic        f3_ok;
    logic        misal;
    logic [1:0]  start_err;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rd_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    // Decode the incoming request directly from the inputs: the error must be
    // known on the start edge to choose between REQ and DONE.
    always_comb begin
        f3_ok = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                         : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (!f3_ok)      start_err = ERR_FUNCT3;
        else if (misal)  start_err = ERR_MISALGN;
        else             start_err = ERR_OK;
    end

    assign timeout_hit = (wait_cnt == CNT_LAST);

    // Lane steering from the latched operation; only legal codes reach REQ.
    always_comb begin
        case (op_f3[1:0])
            2'b00:   begin
                be_calc    = 4'b0001 << op_addr[1:0];
                wdata_calc = {4{op_wdata[7:0]}};
            end
            2'b01:   begin
                be_calc    = 4'b0011 << {op_addr[1], 1'b0};
                wdata_calc = {2{op_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = op_wdata;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {op_addr[1:0], 3'b000};
        ld_byte  = rd_shift[7:0];
        ld_half  = op_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_f3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'h0, ld_byte};
            3'b101:  load_val = {16'h0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state and outputs. Everything memory-facing is decoded from
    // the state so an asynchronous reset drops mem_req immediately.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = ERR_OK;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (start) state_nx = (start_err != ERR_OK) ? DONE : REQ;
            end
            REQ: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = op_store;
                mem_addr  = {op_addr[31:2], 2'b00};
                mem_be    = be_calc;
                mem_wdata = wdata_calc;
                // An ack in the last allowed cycle still completes normally.
                if (mem_ack || timeout_hit) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operation latch, wait counter, error code and load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_store <= 1'b0;
            op_f3    <= 3'b000;
            op_addr  <= 32'h0;
            op_wdata <= 32'h0;
            wait_cnt <= 16'h0;
            err_q    <= ERR_OK;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_store <= is_store;
                        op_f3    <= funct3;
                        op_addr  <= addr;
                        op_wdata <= wdata;
                        wait_cnt <= 16'h0;
                        err_q    <= start_err;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        err_q <= ERR_OK;
                        if (!op_store) rdata_q <= load_val;
                    end else if (timeout_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        tick();
        // Scramble the request inputs to prove they were latched.
        start = 1'b0; is_store = ~st; funct3 = 3'b111; addr = 32'hDEAD_BEEF; wdata = 32'h0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_be", mem_be, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // LB at byte 3, ack in first REQ cycle
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        check("lb_req", mem_req, 1);
        check("lb_we", mem_we, 0);
        check("lb_addr", mem_addr, 32'h0000_1000);
        check("lb_be", mem_be, 4'b1000);
        check("lb_busy", busy, 1);
        check("lb_nodone_n1", done, 0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        tick();
        mem_ack = 1'b0;
        check("lb_done_n2", done, 1);
        check("lb_err", err, 0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_req_off", mem_req, 0);
        tick();
        check("lb_idle_done", done, 0);
        check("lb_idle_busy", busy, 0);
        check("lb_idle_err", err, 0);

        // SH at 0x2002, ack after 3 waiting cycles
        issue(1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF);
        for (int i = 0; i < 4; i++) begin
            check("sh_req", mem_req, 1);
            check("sh_we", mem_we, 1);
            check("sh_addr", mem_addr, 32'h0000_2000);
            check("sh_be", mem_be, 4'b1100);
            check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
            check("sh_nodone", done, 0);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("sh_done", done, 1);
        check("sh_err", err, 0);
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        tick();

        // Misaligned LW: straight to DONE
        issue(1'b0, 3'b010, 32'h0000_0001, 32'h0);
        check("misal_req", mem_req, 0);
        check("misal_done", done, 1);
        check("misal_err", err, 2'b01);
        check("misal_rdata", rdata, 32'hFFFF_FF80);
        tick();
        check("misal_idle", busy, 0);

        // Illegal load funct3
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        check("ill_ld_req", mem_req, 0);
        check("ill_ld_done", done, 1);
        check("ill_ld_err", err, 2'b10);
        tick();

        // Illegal store funct3 on a misaligned address: funct3 wins
        issue(1'b1, 3'b100, 32'h0000_0001, 32'h0);
        check("ill_st_err", err, 2'b10);
        check("ill_st_done", done, 1);
        tick();

        // LHU with no ack: 4 cycles of mem_req then timeout
        issue(1'b0, 3'b101, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_req", mem_req, 1);
            check("to_be", mem_be, 4'b0011);
            tick();
        end
        check("to_req_off", mem_req, 0);
        check("to_done", done, 1);
        check("to_err", err, 2'b11);
        check("to_rdata", rdata, 32'hFFFF_FF80);
        tick();
        check("to_idle", busy, 0);

        // Reset pulse in the second REQ cycle
        issue(1'b0, 3'b100, 32'h0000_0000, 32'h0);
        tick();
        check("rr_req_before", mem_req, 1);
        reset = 1'b1;
        #2;
        check("rr_req_async", mem_req, 0);
        check("rr_busy", busy, 0);
        check("rr_rdata", rdata, 0);
        reset = 1'b0;
        tick();
        check("rr_nodone", done, 0);
        check("rr_idle", busy, 0);
        // LBU byte 1 afterwards completes normally
        issue(1'b0, 3'b100, 32'h0000_0001, 32'h0);
        check("rr_lbu_be", mem_be, 4'b0010);
        mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
        tick();
        mem_ack = 1'b0;
        check("rr_lbu_done", done, 1);
        check("rr_lbu_rdata", rdata, 32'h0000_009A);
        tick();

        // Stray ack in IDLE
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_done", done, 0);
        check("stray_req", mem_req, 0);

        // LH at halfword 1 with start re-pulsed while busy
        issue(1'b0, 3'b001, 32'h0000_0006, 32'h0);
        check("lh_be", mem_be, 4'b1100);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
        tick();
        start = 1'b0; mem_ack = 1'b0;
        check("lh_done", done, 1);
        check("lh_rdata", rdata, 32'hFFFF_8001);
        tick();
        check("lh_no_extra_busy", busy, 0);
        check("lh_no_extra_done", done, 0);
        tick();
        check("lh_no_extra_req", mem_req, 0);

        // SB lane replication, then LW full word
        issue(1'b1, 3'b000, 32'h0000_0022, 32'h1234_56A5);
        check("sb_be", mem_be, 4'b0100);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sb_rdata_kept", rdata, 32'hFFFF_8001);
        tick();
        issue(1'b0, 3'b010, 32'h0000_0008, 32'h0);
        check("lw_be", mem_be, 4'b1111);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("lw_rdata", rdata, 32'hCAFE_F00D);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
